// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: bytes in over valid/ready, MSB-first serial out at clk_32f, COM for training and idle fill.
// Latency: a byte accepted at boundary cycle T drives bit 7 at T+1 and bit 0 at T+8.
// Backpressure: ready_out only at RUN byte boundaries; SKIP_INSERT_EN adds a forced COM every SKIP_INTERVAL data bytes.
module paralelo_serial_tx #(
    parameter logic [7:0] COM_SYMBOL    = 8'hBC,
`ifdef SKIP_INSERT_EN
    parameter int         SKIP_INTERVAL = 16,
`endif
    parameter int         TRAIN_COMS    = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_start,
    output logic       tx_active
);

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] train_cnt_q, train_cnt_d;
    logic       tx_active_q, tx_active_d;
    logic       boundary;
    logic       force_com;
    logic       take;
`ifdef SKIP_INSERT_EN
    logic [7:0] skip_cnt_q, skip_cnt_d;
`endif

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q     <= TRAIN;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd7;
            train_cnt_q <= 4'd0;
            tx_active_q <= 1'b0;
`ifdef SKIP_INSERT_EN
            skip_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
            tx_active_q <= tx_active_d;
`ifdef SKIP_INSERT_EN
            skip_cnt_q  <= skip_cnt_d;
`endif
        end
    end

    always_comb begin
        boundary    = (bit_cnt_q == 3'd7);
        force_com   = 1'b0;
`ifdef SKIP_INSERT_EN
        force_com   = (skip_cnt_q == 8'(SKIP_INTERVAL));
        skip_cnt_d  = skip_cnt_q;
`endif
        ready_out   = boundary && (state_q == RUN) && !force_com;
        take        = ready_out && valid_in;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        shreg_d     = {shreg_q[6:0], 1'b0};
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        tx_active_d = tx_active_q;

        if (boundary) begin
            shreg_d     = take ? data_in : COM_SYMBOL;
            tx_active_d = take;
`ifdef SKIP_INSERT_EN
            // Every COM, forced or idle, restarts the run of data bytes.
            skip_cnt_d  = take ? (skip_cnt_q + 8'd1) : 8'd0;
`endif
            if (state_q == TRAIN) begin
                train_cnt_d = train_cnt_q + 4'd1;
                if (train_cnt_q == 4'(TRAIN_COMS - 1)) begin
                    state_d = RUN;
                end
            end
        end
    end

    assign data_out   = shreg_q[7];
    assign byte_start = (bit_cnt_q == 3'd0);
    assign tx_active  = tx_active_q;

endmodule
